// File: rtl/fetch_unit.sv
// Instruction fetch stage: 64x32 instruction memory, PC and a FETCH/HALTED FSM feeding IF_ID.
// One-cycle fetch latency; stall holds PC/IF_ID, a branch squashes to NOP, HLT parks fetch until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] NOP_WORD   = 32'h38000000,
    parameter logic [5:0]  HLT_OPCODE = 6'b001101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_we,
    input  logic [5:0]  imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [63:0] IF_ID,
    output logic        halted
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    logic [31:0] imem_q [64];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] if_id_q, if_id_d;
    logic        halted_q, halted_d;
    logic [31:0] fetch_word;

    // Memory is deliberately outside the reset domain so programs survive reset.
    always_ff @(posedge clock) begin
        if (imem_we) begin
            imem_q[imem_addr] <= imem_wdata;
        end
    end

    assign fetch_word = imem_q[pc_q[5:0]];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        if_id_d  = if_id_q;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    if_id_d = {pc_q, NOP_WORD};
                    pc_d    = branch_target;
                end else if (!stall) begin
                    if_id_d = {pc_q, fetch_word};
                    pc_d    = pc_q + 32'd1;
                    if (fetch_word[31:26] == HLT_OPCODE) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if_id_d = {pc_q, NOP_WORD};
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            if_id_q  <= {32'h0, NOP_WORD};
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            halted_q <= halted_d;
        end
    end

    assign IF_ID  = if_id_q;
    assign halted = halted_q;

endmodule
